mult_uart_sequencer: RTL and testbench
======================================

// Module: mult_uart_sequencer
// PURPOSE
// - Control sequencer between the UART byte interface and the wide multiplier datapath.
// - Assembles operands A and B from the received octet stream, 16 octets each, MSB octet first.
// - Pulses the multiplier start, latches the product, and streams it back as 32 octets, MSB first.
// - Aborts a partly received operand on an inter-byte timeout.
// PARAMETERS
// OP_W            128    operand width in bits; multiple of 8; OP_BYTES = OP_W/8
// RES_W           256    product width in bits; equals 2*OP_W; RES_BYTES = RES_W/8
// TIMEOUT_CYCLES  12960  max idle clocks between rx bytes while loading (3 frames at 432 clk/bit)
// PORTS
// CLK_IN       in   1      system clock; all logic rising-edge
// resetIn      in   1      asynchronous, active-low reset
// rx_data      in   8      received octet from the UART receiver
// rx_valid     in   1      1-cycle strobe: rx_data valid
// tx_data      out  8      octet to the UART transmitter
// tx_valid     out  1      tx_data valid; held until accepted
// tx_ready     in   1      transmitter accepts the octet when tx_valid & tx_ready
// mult_a       out  OP_W   operand A to the multiplier
// mult_b       out  OP_W   operand B to the multiplier
// mult_start   out  1      1-cycle start pulse
// mult_done    in   1      1-cycle strobe: mult_result valid
// mult_result  in   RES_W  product from the multiplier
// busy         out  1      high in every state except IDLE
// timeout_err  out  1      1-cycle pulse when a load is aborted
// overrun_err  out  1      1-cycle pulse when rx_valid arrives outside LOAD_A/LOAD_B
// BEHAVIOUR
// - Reset (async, resetIn=0) clears all outputs, registers, byte counter and timeout counter; state = IDLE.
// - States:
//   - IDLE: first rx_valid shifts the byte into A, sets cnt=1 and moves to LOAD_A.
//   - LOAD_A: each rx_valid shifts the byte into A: a <= {a[OP_W-9:0], rx_data}; cnt++.
//     On the byte that makes cnt==OP_BYTES: cnt <= 0 and move to LOAD_B.
//   - LOAD_B: same rule, shifting into B; on the last byte move to START.
//   - START: mult_start=1 for exactly one cycle, then move to WAIT.
//     mult_start is asserted the cycle after the last B byte is registered.
//   - WAIT: on mult_done, capture mult_result into res_q, set cnt=0 and move to SEND.
//   - SEND: tx_data = res_q[RES_W-1 -: 8]; tx_valid=1.
//     On tx_valid & tx_ready: shift res_q left by 8 and cnt++.
//     After the RES_BYTES-th accept: tx_valid=0 and move to IDLE.
// - mult_a and mult_b hold their values from START until the next load begins. They are never cleared mid-operation.
// - Timeout: the counter clears on every rx_valid and counts in LOAD_A/LOAD_B only.
//   When it reaches TIMEOUT_CYCLES: timeout_err pulses, cnt=0, state=IDLE, and the partial operand is discarded.
// - rx_valid on the same cycle as the timeout terminal count: the byte wins, no timeout.
// - rx_valid in START, WAIT or SEND: the byte is dropped and overrun_err pulses. State is unaffected.
// - mult_done outside WAIT is ignored. WAIT has no timeout; only reset exits a hung multiplier.
// - tx_data and tx_valid must not change while tx_valid=1 and tx_ready=0.
// - Reset mid-operation: immediate return to IDLE; an in-flight tx octet is abandoned (tx_valid drops asynchronously).
// STRUCTURE
// - Package mult_seq_pkg holds:
//   - state encoding localparams ST_IDLE..ST_SEND (3 bits);
//   - OP_BYTES and RES_BYTES derivations;
//   - the default timeout constant CLKS_PER_BIT=432.
// - One natural sub-module, mult_seq_timeout: a clear/enable/terminal-count counter of width clog2(TIMEOUT_CYCLES+1).
// - FSM, operand shift registers and result shift register live in the top of this module.
// TESTING
// 1. Reset: hold resetIn=0 for 10 clocks -> all outputs 0 and busy=0. Release -> still idle.
// 2. Nominal: send A=128'd920 then B=128'd3 (32 octets, MSB first); model returns 256'd2760 after 5 clocks.
//    -> exactly one mult_start; mult_a=920 and mult_b=3 at the start pulse.
//    -> tx octets: 30 x 0x00, then 0x0A, then 0xC8; busy=0 after the last accept.
// 3. Timeout: send 5 octets, then idle 12960 clocks -> timeout_err pulses once and busy=0.
//    A fresh 32-octet sequence then runs normally.
// 4. Backpressure: hold tx_ready=0 for 100 clocks in SEND -> tx_data/tx_valid stable. Release -> all 32 octets in order, none lost.
// 5. Overrun and spurious done:
//    -> rx_valid during WAIT: overrun_err pulses and the result is unchanged.
//    -> mult_done in IDLE: no state change and no tx activity.
// 6. Async reset mid-SEND after 10 octets -> immediate IDLE with tx_valid=0; the next transaction is correct.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared constants, state encoding and byte-count helper for the multiplier UART sequencer.
package mult_seq_pkg;

  // UART timing: the inter-byte timeout defaults to three 10-bit frames.
  localparam int unsigned CLKS_PER_BIT       = 432;
  localparam int unsigned FRAME_BITS         = 10;
  localparam int unsigned TIMEOUT_FRAMES     = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = TIMEOUT_FRAMES * FRAME_BITS * CLKS_PER_BIT;

  // Default datapath sizes.
  localparam int unsigned DEF_OP_W  = 128;
  localparam int unsigned DEF_RES_W = 2 * DEF_OP_W;

  // Number of octets in a bit width (width is a multiple of 8).
  function automatic int unsigned octets(input int unsigned width);
    return width / 8;
  endfunction

  localparam int unsigned OP_BYTES  = octets(DEF_OP_W);
  localparam int unsigned RES_BYTES = octets(DEF_RES_W);

  // Sequencer states, 3-bit encoding.
  localparam int unsigned STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_SEND   = 3'd5
  } state_e;

endpackage

// File: rtl/mult_seq_timeout.sv
// Inter-byte idle counter with clear, enable and saturating terminal count.
// Ports:
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_clr     synchronous clear (dominates enable)
//   i_en      count enable
//   o_term_c  combinational: counter has reached TERM
module mult_seq_timeout #(
  parameter int unsigned TERM = 12960
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term_c
);

  localparam int unsigned TW = $clog2(TERM + 1);

  logic [TW-1:0] r_cnt;

  // Count up while enabled; hold at the terminal value until cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_term_c) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_term_c = (r_cnt == TW'(TERM));

endmodule

// File: rtl/mult_uart_sequencer.sv
// Control sequencer between a UART byte interface and a wide multiplier.
// Loads operand A then B (OP_W/8 octets each, MSB first), pulses mult_start,
// captures the product and streams it back MSB octet first with a
// valid/ready handshake. A stalled load is aborted after TIMEOUT_CYCLES.
// Ports:
//   CLK_IN       system clock
//   resetIn      asynchronous active-low reset
//   rx_data      received octet;        rx_valid   1-cycle strobe
//   tx_data      octet to transmitter;  tx_valid   held until tx_ready
//   tx_ready     transmitter accept
//   mult_a/b     operands, stable from the start pulse onward
//   mult_start   1-cycle start pulse;   mult_done  1-cycle result strobe
//   mult_result  product
//   busy         not in IDLE
//   timeout_err  1-cycle pulse on aborted load
//   overrun_err  1-cycle pulse on a byte received outside the load states
module mult_uart_sequencer
  import mult_seq_pkg::*;
#(
  parameter int unsigned OP_W           = DEF_OP_W,
  parameter int unsigned RES_W          = 2 * OP_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             CLK_IN,
  input  logic             resetIn,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [OP_W-1:0]  mult_a,
  output logic [OP_W-1:0]  mult_b,
  output logic             mult_start,
  input  logic             mult_done,
  input  logic [RES_W-1:0] mult_result,
  output logic             busy,
  output logic             timeout_err,
  output logic             overrun_err
);

  localparam int unsigned OP_N  = octets(OP_W);
  localparam int unsigned RES_N = octets(RES_W);
  localparam int unsigned CNT_W = $clog2(RES_N + 1);
  localparam logic [CNT_W-1:0] OP_LAST  = CNT_W'(OP_N - 1);
  localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RES_N - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_a_sh;
  logic [OP_W-1:0]  r_b_sh;
  logic [OP_W-1:0]  r_mult_a;
  logic [OP_W-1:0]  r_mult_b;
  logic [RES_W-1:0] r_res;
  logic             r_tx_valid;
  logic             r_mult_start;
  logic             r_busy;
  logic             r_timeout_err;
  logic             r_overrun_err;

  logic w_loading;
  logic w_to_term;
  logic w_rx_blocked;

  assign w_loading    = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  assign w_rx_blocked = (r_state == ST_START) || (r_state == ST_WAIT) || (r_state == ST_SEND);

  // Idle timer: restarts on every received byte, runs only while loading.
  mult_seq_timeout #(
    .TERM (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (CLK_IN),
    .i_rst_n  (resetIn),
    .i_clr    (rx_valid || !w_loading),
    .i_en     (w_loading),
    .o_term_c (w_to_term)
  );

  // Sequencer FSM with operand and result shift registers.
  always_ff @(posedge CLK_IN or negedge resetIn) begin
    if (!resetIn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_a_sh        <= '0;
      r_b_sh        <= '0;
      r_mult_a      <= '0;
      r_mult_b      <= '0;
      r_res         <= '0;
      r_tx_valid    <= 1'b0;
      r_mult_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_mult_start  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= rx_valid && w_rx_blocked;

      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            r_a_sh  <= {r_a_sh[OP_W-9:0], rx_data};
            r_cnt   <= CNT_W'(1);
            r_state <= ST_LOAD_A;
            r_busy  <= 1'b1;
          end
        end

        ST_LOAD_A: begin
          // A byte on the terminal-count cycle takes priority over the timeout.
          if (rx_valid) begin
            r_a_sh <= {r_a_sh[OP_W-9:0], rx_data};
            if (r_cnt == OP_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_LOAD_B;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (w_to_term) begin
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
            r_a_sh        <= '0;
            r_b_sh        <= '0;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end
        end

        ST_LOAD_B: begin
          if (rx_valid) begin
            r_b_sh <= {r_b_sh[OP_W-9:0], rx_data};
            if (r_cnt == OP_LAST) begin
              // Publish both operands together with the start pulse.
              r_mult_a     <= r_a_sh;
              r_mult_b     <= {r_b_sh[OP_W-9:0], rx_data};
              r_mult_start <= 1'b1;
              r_cnt        <= '0;
              r_state      <= ST_START;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (w_to_term) begin
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
            r_a_sh        <= '0;
            r_b_sh        <= '0;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
          end
        end

        ST_START: begin
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (mult_done) begin
            r_res      <= mult_result;
            r_cnt      <= '0;
            r_tx_valid <= 1'b1;
            r_state    <= ST_SEND;
          end
        end

        ST_SEND: begin
          // Octet and valid only move on an accepted handshake.
          if (r_tx_valid && tx_ready) begin
            r_res <= {r_res[RES_W-9:0], 8'h00};
            if (r_cnt == RES_LAST) begin
              r_tx_valid <= 1'b0;
              r_cnt      <= '0;
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data     = r_res[RES_W-1 -: 8];
  assign tx_valid    = r_tx_valid;
  assign mult_a      = r_mult_a;
  assign mult_b      = r_mult_b;
  assign mult_start  = r_mult_start;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_mult_uart_sequencer.sv
// Directed self-checking bench for mult_uart_sequencer with a behavioural multiplier.
module tb_mult_uart_sequencer;

  logic         CLK_IN = 1'b0;
  logic         resetIn;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [127:0] mult_a;
  logic [127:0] mult_b;
  logic         mult_start;
  logic         mult_done;
  logic [255:0] mult_result;
  logic         busy;
  logic         timeout_err;
  logic         overrun_err;

  always #5 CLK_IN = ~CLK_IN;

  mult_uart_sequencer dut (
    .CLK_IN      (CLK_IN),
    .resetIn     (resetIn),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_start  (mult_start),
    .mult_done   (mult_done),
    .mult_result (mult_result),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  int checks = 0;
  int errors = 0;

  // Observation counters and operand capture at the start pulse.
  int           start_hi = 0;
  int           ovr_cnt  = 0;
  int           to_cnt   = 0;
  logic [127:0] cap_a    = '0;
  logic [127:0] cap_b    = '0;

  always @(negedge CLK_IN) begin
    if (mult_start === 1'b1) begin
      start_hi = start_hi + 1;
      cap_a    = mult_a;
      cap_b    = mult_b;
    end
    if (overrun_err === 1'b1) ovr_cnt = ovr_cnt + 1;
    if (timeout_err === 1'b1) to_cnt = to_cnt + 1;
  end

  // Behavioural multiplier: answers mdelay clocks after the start pulse.
  int           mdelay      = 5;
  logic         mult_done_m = 1'b0;
  logic [255:0] model_res   = '0;
  logic         spur_done   = 1'b0;
  logic [255:0] spur_res    = '0;

  assign mult_done   = mult_done_m | spur_done;
  assign mult_result = spur_done ? spur_res : model_res;

  initial begin
    logic [127:0] ma;
    logic [127:0] mb;
    forever begin
      @(negedge CLK_IN);
      if (mult_start === 1'b1) begin
        ma = mult_a;
        mb = mult_b;
        repeat (mdelay) @(posedge CLK_IN);
        #1;
        model_res   = 256'(ma) * 256'(mb);
        mult_done_m = 1'b1;
        @(posedge CLK_IN);
        #1;
        mult_done_m = 1'b0;
      end
    end
  end

  // Received octet stream.
  logic [7:0]   oct [32];
  int           n_oct;
  logic [255:0] got;

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK_IN);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK_IN);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_op(input logic [127:0] v);
    for (int i = 15; i >= 0; i--) send_byte(v[i*8 +: 8]);
  endtask

  // Samples once per cycle at posedge+1; an octet is taken when valid&ready.
  task automatic recv(input int want, input int bound);
    n_oct = 0;
    got   = '0;
    for (int c = 0; c < bound; c++) begin
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        oct[n_oct] = tx_data;
        got        = {got[247:0], tx_data};
        n_oct      = n_oct + 1;
        if (n_oct >= want) break;
      end
      @(posedge CLK_IN);
      #1;
    end
  endtask

  task automatic run_txn(input logic [127:0] a, input logic [127:0] b, input logic [255:0] exp);
    send_op(a);
    send_op(b);
    recv(32, 800);
    checks++;
    if (n_oct !== 32) begin errors++; $display("FAIL txn_octets got=%0d exp=32", n_oct); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL txn_product got=%0h exp=%0h", got, exp); end
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic test_reset();
    resetIn = 1'b0;
    repeat (10) @(posedge CLK_IN);
    @(negedge CLK_IN);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
    checks++;
    if (mult_a !== '0 || mult_b !== '0) begin errors++; $display("FAIL reset_operands got=%0h/%0h exp=0/0", mult_a, mult_b); end
    checks++;
    if (mult_start !== 1'b0) begin errors++; $display("FAIL reset_mult_start got=%b exp=0", mult_start); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (timeout_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++; $display("FAIL reset_errs got=%b%b exp=00", timeout_err, overrun_err);
    end
    resetIn = 1'b1;
    repeat (3) @(negedge CLK_IN);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL release_idle got busy=%b tx_valid=%b exp=0/0", busy, tx_valid);
    end
  endtask

  task automatic test_nominal();
    int s0;
    int bad;
    s0 = start_hi;
    send_op(128'd920);
    send_op(128'd3);
    recv(32, 800);
    checks++;
    if (n_oct !== 32) begin errors++; $display("FAIL nom_octets got=%0d exp=32", n_oct); end
    checks++;
    if (start_hi - s0 !== 1) begin errors++; $display("FAIL nom_start_pulses got=%0d exp=1", start_hi - s0); end
    checks++;
    if (cap_a !== 128'd920) begin errors++; $display("FAIL nom_mult_a got=%0d exp=920", cap_a); end
    checks++;
    if (cap_b !== 128'd3) begin errors++; $display("FAIL nom_mult_b got=%0d exp=3", cap_b); end
    bad = 0;
    for (int i = 0; i < 30; i++) if (oct[i] !== 8'h00) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL nom_leading_zero got=%0d nonzero exp=0", bad); end
    checks++;
    if (oct[30] !== 8'h0A) begin errors++; $display("FAIL nom_octet30 got=%0h exp=0a", oct[30]); end
    checks++;
    if (oct[31] !== 8'hC8) begin errors++; $display("FAIL nom_octet31 got=%0h exp=c8", oct[31]); end
    @(posedge CLK_IN);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL nom_end_idle got busy=%b tx_valid=%b exp=0/0", busy, tx_valid);
    end
  endtask

  task automatic test_timeout();
    int t0;
    int first;
    t0    = to_cnt;
    first = -1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)));
    for (int c = 1; c <= 13100; c++) begin
      @(negedge CLK_IN);
      if (timeout_err === 1'b1 && first < 0) first = c;
      if (first >= 0 && c > first + 20) break;
    end
    checks++;
    if (first < 12958 || first > 12966) begin
      errors++; $display("FAIL to_latency got=%0d exp=12958..12966", first);
    end
    checks++;
    if (to_cnt - t0 !== 1) begin errors++; $display("FAIL to_pulses got=%0d exp=1", to_cnt - t0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL to_busy got=%b exp=0", busy); end
    run_txn(128'd7, 128'd6, 256'd42);
  endtask

  task automatic test_backpressure();
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] exp;
    logic [7:0]   first;
    int           seen;
    int           unstable;
    a   = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
    b   = 128'h8000_0000_0000_0000_0000_0000_0000_0003;
    exp = 256'(a) * 256'(b);
    tx_ready = 1'b0;
    send_op(a);
    send_op(b);
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK_IN);
      if (tx_valid === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen !== 1) begin errors++; $display("FAIL bp_valid_seen got=%0d exp=1", seen); end
    first    = tx_data;
    unstable = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK_IN);
      if (tx_valid !== 1'b1 || tx_data !== first) unstable++;
    end
    checks++;
    if (unstable !== 0) begin errors++; $display("FAIL bp_stable got=%0d changes exp=0", unstable); end
    checks++;
    if (first !== exp[255:248]) begin errors++; $display("FAIL bp_first_octet got=%0h exp=%0h", first, exp[255:248]); end
    tx_ready = 1'b1;
    recv(32, 800);
    checks++;
    if (n_oct !== 32) begin errors++; $display("FAIL bp_octets got=%0d exp=32", n_oct); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bp_product got=%0h exp=%0h", got, exp); end
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic test_overrun();
    int o0;
    int s0;
    int bad;
    mdelay = 20;
    o0 = ovr_cnt;
    send_op(128'd100);
    send_op(128'd5);
    repeat (3) @(posedge CLK_IN);
    send_byte(8'hFF);
    checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL ovr_in_wait got busy=%b tx_valid=%b exp=1/0", busy, tx_valid);
    end
    recv(32, 800);
    checks++;
    if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt - o0); end
    checks++;
    if (got !== 256'd500) begin errors++; $display("FAIL ovr_product got=%0h exp=1f4", got); end
    mdelay = 5;
    @(posedge CLK_IN);
    #1;
    s0 = start_hi;
    spur_res  = 256'hDEAD_BEEF;
    spur_done = 1'b1;
    @(posedge CLK_IN);
    #1;
    spur_done = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK_IN);
      if (busy !== 1'b0 || tx_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL spur_done_idle got=%0d active cycles exp=0", bad); end
    checks++;
    if (start_hi !== s0) begin errors++; $display("FAIL spur_done_start got=%0d exp=%0d", start_hi, s0); end
  endtask

  task automatic test_reset_mid_send();
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] exp;
    a   = 128'h0123_4567_89AB_CDEF_1122_3344_5566_7788;
    b   = 128'hA5A5_0000_FFFF_1234_0000_0000_0000_0101;
    exp = 256'(a) * 256'(b);
    send_op(a);
    send_op(b);
    recv(10, 800);
    checks++;
    if (n_oct !== 10 || got[79:0] !== exp[255:176]) begin
      errors++; $display("FAIL rst_first10 got=%0d/%0h exp=10/%0h", n_oct, got[79:0], exp[255:176]);
    end
    @(posedge CLK_IN);
    #2;
    resetIn = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async got tx_valid=%b busy=%b exp=0/0", tx_valid, busy);
    end
    repeat (3) @(posedge CLK_IN);
    #1;
    resetIn = 1'b1;
    run_txn(128'h1_0000_0000, 128'h3_0000_0005, 256'h3_0000_0005_0000_0000);
  endtask

  initial begin
    resetIn  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    test_reset();
    test_nominal();
    test_timeout();
    test_backpressure();
    test_overrun();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
